wb_mem_arbiter: RTL and testbench

Wishbone B3 arbiter that shares the single system memory slave (wb_bfm_memory0 in simulation, on-chip RAM in synthesis) between the OR1200 instruction bus, OR1200 data bus and the JTAG debug interface inside orpsoc_top. Fair round-robin grant, one owner per bus cycle, grant held until the owner drops cyc, so bursts and read-modify-write sequences are never split. An optional watchdog terminates stalled cycles with err.

---
 rtl/wb_mem_arbiter.sv | 143 ++++++++++++++
 tb/tb_wb_mem_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_mem_arbiter.sv
// rtl/wb_mem_arbiter.sv - round-robin Wishbone arbiter sharing one memory slave
// Optional stall watchdog compiled in with WB_ARB_WATCHDOG_EN.
module wb_mem_arbiter #(
    parameter int NUM_MASTERS = 3,
    parameter int TIMEOUT     = 255
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic [NUM_MASTERS-1:0]   m_cyc_i,
    input  logic [NUM_MASTERS-1:0]   m_stb_i,
    input  logic [NUM_MASTERS-1:0]   m_we_i,
    input  logic [32*NUM_MASTERS-1:0] m_adr_i,
    input  logic [32*NUM_MASTERS-1:0] m_dat_i,
    input  logic [4*NUM_MASTERS-1:0] m_sel_i,
    input  logic [3*NUM_MASTERS-1:0] m_cti_i,
    input  logic [2*NUM_MASTERS-1:0] m_bte_i,
    output logic [31:0]              m_dat_o,
    output logic [NUM_MASTERS-1:0]   m_ack_o,
    output logic [NUM_MASTERS-1:0]   m_err_o,
    output logic                     s_cyc_o,
    output logic                     s_stb_o,
    output logic                     s_we_o,
    output logic [31:0]              s_adr_o,
    output logic [31:0]              s_dat_o,
    output logic [3:0]               s_sel_o,
    output logic [2:0]               s_cti_o,
    output logic [1:0]               s_bte_o,
    input  logic [31:0]              s_dat_i,
    input  logic                     s_ack_i,
    input  logic                     s_err_i,
    output logic [NUM_MASTERS-1:0]   gnt_o,
    output logic                     timeout_o
);
    localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    typedef enum logic {IDLE = 1'b0, OWNED = 1'b1} state_t;

    state_t                 r_state, w_state_nxt;
    logic [IW-1:0]          r_owner, w_owner_nxt;
    logic [IW-1:0]          r_last, w_last_nxt;
    logic [IW-1:0]          w_pick;
    logic [NUM_MASTERS-1:0] r_gnt, w_gnt_nxt;
    logic                   w_any_req;
    logic                   w_owned;
    logic                   w_own_cyc;
    logic                   w_own_stb;
    logic                   w_timeout;
    int                     w_idx;

    assign w_owned   = (r_state == OWNED);
    assign w_own_cyc = m_cyc_i[r_owner];
    assign w_own_stb = m_stb_i[r_owner];

    // Descending scan: the requester nearest after r_last is written last and wins.
    always_comb begin
        w_pick    = r_last;
        w_any_req = 1'b0;
        w_idx     = 0;
        for (int k = NUM_MASTERS; k >= 1; k--) begin
            w_idx = (int'(r_last) + k) % NUM_MASTERS;
            if (m_cyc_i[w_idx]) begin
                w_pick    = IW'(w_idx);
                w_any_req = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last;
        w_gnt_nxt   = r_gnt;
        case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = OWNED;
                    w_owner_nxt = w_pick;
                    w_gnt_nxt   = NUM_MASTERS'(1) << w_pick;
                end
            end
            OWNED: begin
                if (!w_own_cyc) begin
                    w_state_nxt = IDLE;
                    w_last_nxt  = r_owner;
                    w_gnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state <= IDLE;
            r_owner <= '0;
            r_last  <= IW'(NUM_MASTERS - 1);
            r_gnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_last  <= w_last_nxt;
            r_gnt   <= w_gnt_nxt;
        end
    end

`ifdef WB_ARB_WATCHDOG_EN
    logic [7:0] r_wd_cnt;

    assign w_timeout = w_owned && (r_wd_cnt == 8'(TIMEOUT));

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_wd_cnt <= '0;
        end else if (!w_owned || !w_own_cyc || w_timeout || s_ack_i || s_err_i) begin
            r_wd_cnt <= '0;
        end else if (w_own_stb) begin
            r_wd_cnt <= r_wd_cnt + 8'd1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // Slave side follows the owner combinationally; everything is zero while IDLE.
    assign s_cyc_o = w_owned & w_own_cyc;
    assign s_stb_o = w_owned & w_own_stb & ~w_timeout;
    assign s_we_o  = w_owned & m_we_i[r_owner];
    assign s_adr_o = w_owned ? m_adr_i[32*r_owner +: 32] : '0;
    assign s_dat_o = w_owned ? m_dat_i[32*r_owner +: 32] : '0;
    assign s_sel_o = w_owned ? m_sel_i[4*r_owner +: 4]   : '0;
    assign s_cti_o = w_owned ? m_cti_i[3*r_owner +: 3]   : '0;
    assign s_bte_o = w_owned ? m_bte_i[2*r_owner +: 2]   : '0;

    assign m_dat_o   = s_dat_i;
    assign m_ack_o   = w_owned ? (NUM_MASTERS'(s_ack_i) << r_owner) : '0;
    assign m_err_o   = w_owned ? (NUM_MASTERS'(s_err_i | w_timeout) << r_owner) : '0;
    assign gnt_o     = r_gnt;
    assign timeout_o = w_timeout;

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// tb/tb_wb_mem_arbiter.sv - directed and randomized checks of wb_mem_arbiter
// Watchdog expectations switch on WB_ARB_WATCHDOG_EN.
module tb_wb_mem_arbiter;
    localparam int N = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    cyc, stb, we;
    logic [32*N-1:0] adr, dat;
    logic [4*N-1:0]  sel;
    logic [3*N-1:0]  cti;
    logic [2*N-1:0]  bte;
    logic [31:0]     m_dat_o;
    logic [N-1:0]    m_ack_o, m_err_o, gnt_o;
    logic            s_cyc_o, s_stb_o, s_we_o, timeout_o;
    logic [31:0]     s_adr_o, s_dat_o;
    logic [3:0]      s_sel_o;
    logic [2:0]      s_cti_o;
    logic [1:0]      s_bte_o;
    logic [31:0]     s_dat_i;
    logic            s_ack_i, s_err_i;

    int checks = 0;
    int errors = 0;

    wb_mem_arbiter #(.NUM_MASTERS(N), .TIMEOUT(16)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .m_cyc_i(cyc), .m_stb_i(stb), .m_we_i(we),
        .m_adr_i(adr), .m_dat_i(dat), .m_sel_i(sel),
        .m_cti_i(cti), .m_bte_i(bte),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
        .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
        .gnt_o(gnt_o), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input int i, input logic c, input logic [31:0] a, input logic [2:0] t);
        cyc[i] = c;
        stb[i] = c;
        adr[32*i +: 32] = a;
        cti[3*i +: 3] = t;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc = '0; stb = '0; we = '0; adr = '0; dat = '0; sel = '0; cti = '0; bte = '0;
        s_dat_i = '0; s_ack_i = 1'b0; s_err_i = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    // Reference model: owner (-1 = none) and last owner, advanced once per clock edge.
    int mo, ml;
    task automatic model_step(input logic [N-1:0] c);
        bit found;
        if (mo < 0) begin
            found = 0;
            for (int k = 1; k <= N; k++) begin
                if (!found && c[(ml + k) % N]) begin
                    mo = (ml + k) % N;
                    found = 1;
                end
            end
        end else if (!c[mo]) begin
            ml = mo;
            mo = -1;
        end
    endtask

    int          rem [N];
    logic [N-1:0] got;
    int          stall;
    logic [N-1:0] e_gnt, e_ack, e_err;
    logic [31:0] e_adr;
    logic [41:0] e_misc;
    logic        e_cyc;
    int          r;

    initial begin
        // reset state
        do_reset();
        check("reset_gnt", gnt_o, 0);
        check("reset_scyc", s_cyc_o, 0);
        check("reset_ack", m_ack_o, 0);
        check("reset_timeout", timeout_o, 0);

        // single master 1 read
        set_m(1, 1'b1, 32'h0000_0100, 3'b000);
        #1;
        check("t1_gnt_lat", gnt_o, 0);
        check("t1_scyc_lat", s_cyc_o, 0);
        tick();
        check("t1_gnt", gnt_o, 3'b010);
        check("t1_scyc", s_cyc_o, 1);
        check("t1_sadr", s_adr_o, 32'h0000_0100);
        tick();
        tick();
        s_ack_i = 1'b1;
        s_dat_i = 32'hCAFE_F00D;
        #1;
        check("t1_ack", m_ack_o, 3'b010);
        check("t1_dat", m_dat_o, 32'hCAFE_F00D);
        tick();
        s_ack_i = 1'b0;
        set_m(1, 1'b0, 32'h0000_0100, 3'b000);
        #1;
        check("t1_scyc_drop", s_cyc_o, 0);
        tick();
        check("t1_idle", gnt_o, 0);

        // three-way tie from reset: order 0,1,2 with one idle cycle between
        do_reset();
        for (int i = 0; i < N; i++) set_m(i, 1'b1, 32'h1000 + 32'(i), 3'b000);
        for (int e = 0; e < N; e++) begin
            tick();
            check("t2_gnt", gnt_o, 64'(1 << e));
            check("t2_sadr", s_adr_o, 32'h1000 + 32'(e));
            s_ack_i = 1'b1;
            #1;
            check("t2_ack", m_ack_o, 64'(1 << e));
            tick();
            s_ack_i = 1'b0;
            set_m(e, 1'b0, 32'h1000 + 32'(e), 3'b000);
            #1;
            check("t2_scyc_drop", s_cyc_o, 0);
            check("t2_gnt_hold", gnt_o, 64'(1 << e));
            tick();
            check("t2_bubble", gnt_o, 0);
        end

        // master 0 burst while master 2 waits
        do_reset();
        set_m(0, 1'b1, 32'h400, 3'b010);
        set_m(2, 1'b1, 32'h500, 3'b000);
        tick();
        check("t3_gnt", gnt_o, 3'b001);
        for (int b = 0; b < 4; b++) begin
            cti[2:0] = (b == 3) ? 3'b111 : 3'b010;
            s_ack_i = 1'b1;
            s_dat_i = 32'hB0 + 32'(b);
            #1;
            check("t3_ack", m_ack_o, 3'b001);
            check("t3_cti", s_cti_o, (b == 3) ? 3'b111 : 3'b010);
            check("t3_dat", m_dat_o, 32'hB0 + 32'(b));
            tick();
        end
        set_m(0, 1'b0, 32'h400, 3'b000);
        s_ack_i = 1'b0;
        #1;
        check("t3_noack", m_ack_o, 0);
        tick();
        check("t3_idle", gnt_o, 0);
        s_ack_i = 1'b1;
        #1;
        check("t3_idle_ack_drop", m_ack_o, 0);
        s_ack_i = 1'b0;
        tick();
        check("t3_gnt2", gnt_o, 3'b100);
        check("t3_sadr2", s_adr_o, 32'h500);

        // owner drops while master 1 raises in the same cycle
        set_m(2, 1'b0, 32'h500, 3'b000);
        set_m(1, 1'b1, 32'h600, 3'b000);
        tick();
        check("t4_idle", gnt_o, 0);
        tick();
        check("t4_gnt", gnt_o, 3'b010);
        check("t4_scyc", s_cyc_o, 1);

        // asynchronous reset mid-burst of master 2
        set_m(1, 1'b0, 32'h600, 3'b000);
        set_m(2, 1'b1, 32'h700, 3'b010);
        tick();
        check("t5_idle", gnt_o, 0);
        tick();
        check("t5_gnt2", gnt_o, 3'b100);
        s_ack_i = 1'b1;
        #1;
        check("t5_ack2", m_ack_o, 3'b100);
        #3;
        rst = 1'b1;
        #1;
        check("t5_rst_scyc", s_cyc_o, 0);
        check("t5_rst_gnt", gnt_o, 0);
        check("t5_rst_ack", m_ack_o, 0);
        s_ack_i = 1'b0;
        for (int i = 0; i < N; i++) set_m(i, 1'b1, 32'h800 + 32'(i), 3'b000);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        check("t5_tie_gnt", gnt_o, 3'b001);

        // stalled slave
        do_reset();
        set_m(0, 1'b1, 32'h200, 3'b000);
        tick();
        for (int k = 0; k <= 20; k++) begin
            if (k > 0) tick();
`ifdef WB_ARB_WATCHDOG_EN
            check("t6_timeout", timeout_o, (k == 16) ? 1 : 0);
            check("t6_err", m_err_o, (k == 16) ? 3'b001 : 3'b000);
            check("t6_stb", s_stb_o, (k == 16) ? 0 : 1);
`else
            check("t6_timeout", timeout_o, 0);
            check("t6_err", m_err_o, 0);
            check("t6_stb", s_stb_o, 1);
`endif
        end

        // randomized traffic against the model
        do_reset();
        mo = -1;
        ml = N - 1;
        stall = 0;
        got = '0;
        for (int i = 0; i < N; i++) rem[i] = 0;
        for (int n = 0; n < 2000; n++) begin
            tick();
            model_step(cyc);
            for (int i = 0; i < N; i++) begin
                if (got[i]) rem[i]--;
                if (rem[i] == 0 && !cyc[i] && $urandom_range(0, 2) == 0)
                    rem[i] = $urandom_range(1, 4);
                cyc[i] = (rem[i] > 0);
                stb[i] = cyc[i];
                we[i]  = 1'($urandom);
                adr[32*i +: 32] = $urandom;
                dat[32*i +: 32] = $urandom;
                sel[4*i +: 4]   = 4'($urandom);
                cti[3*i +: 3]   = 3'($urandom);
                bte[2*i +: 2]   = 2'($urandom);
            end
            r = $urandom_range(0, 7);
            s_err_i = (r == 0);
            s_ack_i = (r != 0) && (r >= 4 || stall >= 8);
            s_dat_i = $urandom;
            #1;
            e_gnt = '0; e_ack = '0; e_err = '0; e_adr = '0; e_misc = '0; e_cyc = 1'b0;
            if (mo >= 0) begin
                e_gnt[mo] = 1'b1;
                e_ack[mo] = s_ack_i;
                e_err[mo] = s_err_i;
                e_adr  = adr[32*mo +: 32];
                e_misc = {we[mo], sel[4*mo +: 4], bte[2*mo +: 2], 3'b000, dat[32*mo +: 32]};
                e_cyc  = cyc[mo];
            end
            check("rnd_gnt", gnt_o, e_gnt);
            check("rnd_scyc", s_cyc_o, e_cyc);
            check("rnd_sadr", s_adr_o, e_adr);
            check("rnd_misc", {s_we_o, s_sel_o, s_bte_o, 3'b000, s_dat_o}, e_misc);
            check("rnd_ack", m_ack_o, e_ack);
            check("rnd_err", m_err_o, e_err);
            check("rnd_dat", m_dat_o, s_dat_i);
            check("rnd_timeout", timeout_o, 0);
            got = '0;
            if (mo >= 0 && cyc[mo] && (s_ack_i || s_err_i)) got[mo] = 1'b1;
            if (mo >= 0 && stb[mo] && !s_ack_i && !s_err_i) stall++;
            else stall = 0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
